// File: rtl/byte_word_packer_pkg.sv
// Shared constants and types for the byte-to-word packer and its
// word-to-byte counterpart on the debug/host-load path.
package byte_word_packer_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned WORD_W          = BYTE_W * WORD_BYTES;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  // Byte lane within a word; lane 0 is bits [7:0] (little-endian).
  typedef logic [1:0] lane_idx_t;

endpackage : byte_word_packer_pkg

// File: rtl/packer_idle_timer.sv
// Idle-cycle counter for a partially assembled word. Counts while enabled,
// returns to zero on clear, and flags expire in the cycle the count sits at
// TIMEOUT_CYC-1 so the owner can discard the partial word on the next edge.
module packer_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = byte_word_packer_pkg::TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned       CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority over expiry: an accepted byte in the last cycle wins.
  assign expire = enable & ~clear & (cnt_q == CNT_LAST);

  // Next count: wrap to zero on clear or expiry, otherwise advance while idle.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : packer_idle_timer

// File: rtl/byte_word_packer.sv
// Byte-to-word packer: gathers a valid/ready byte stream into 32-bit
// little-endian words held in a single output register.
// Optional feature macro PACKER_TIMEOUT_EN: discards a partial word after
// TIMEOUT_CYC idle cycles and pulses err_drop; when undefined err_drop is 0.
module byte_word_packer #(
  parameter int unsigned WORD_BYTES  = byte_word_packer_pkg::WORD_BYTES,
  parameter int unsigned BYTE_W      = byte_word_packer_pkg::BYTE_W,
  parameter int unsigned TIMEOUT_CYC = byte_word_packer_pkg::TIMEOUT_CYC_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           byte_valid,
  output logic                           byte_ready,
  input  logic [BYTE_W-1:0]              byte_data,
  input  logic                           flush,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [WORD_BYTES*BYTE_W-1:0]   word_data,
  output byte_word_packer_pkg::lane_idx_t byte_cnt,
  output logic                           err_drop
);

  import byte_word_packer_pkg::*;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(WORD_BYTES - 1);

  logic                         word_valid_q, word_valid_d;
  logic [WORD_BYTES*BYTE_W-1:0] word_data_q,  word_data_d;
  lane_idx_t                    byte_cnt_q,   byte_cnt_d;

  logic byte_accept;
  logic word_take;
  logic timeout_expire;

  // Input stalls only while a finished word waits for its consumer or during flush.
  assign byte_ready  = ~flush & (~word_valid_q | word_ready);
  assign byte_accept = byte_valid & byte_ready;
  assign word_take   = word_valid_q & word_ready;

`ifdef PACKER_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;
  logic err_drop_q;

  assign timer_clear  = byte_accept | flush | (byte_cnt_q == '0);
  assign timer_enable = (byte_cnt_q != '0) & ~byte_accept;

  packer_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timeout_expire)
  );

  // One-cycle drop pulse registered from the timer's expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= timeout_expire;
    end
  end

  assign err_drop = err_drop_q;
`else
  logic unused_timeout;

  // The timeout length only matters when the idle timer is built.
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_expire = 1'b0;
  assign err_drop       = 1'b0;
`endif

  // Next state: handshake clears the word, flush/timeout drop the partial
  // word, and an accepted byte lands in lane byte_cnt (lane 0 after a take).
  always_comb begin
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    byte_cnt_d   = byte_cnt_q;

    if (word_take) begin
      word_valid_d = 1'b0;
      word_data_d  = '0;
    end

    // A pending complete word has no partial lanes, so its data is kept.
    if (flush || timeout_expire) begin
      byte_cnt_d = '0;
      if (!word_valid_q) begin
        word_data_d = '0;
      end
    end

    if (byte_accept) begin
      word_data_d[int'(byte_cnt_q)*BYTE_W +: BYTE_W] = byte_data;
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == LAST_LANE) begin
        word_valid_d = 1'b1;
      end
    end
  end

  // Word register, its valid flag and the lane counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      byte_cnt_q   <= '0;
    end else begin
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign byte_cnt   = byte_cnt_q;

endmodule : byte_word_packer

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer. Expected words are queued when
// their bytes are driven and compared when the DUT hands a word over.
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  byte_data = 8'h00;
  logic        flush = 1'b0;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic [1:0]  byte_cnt;
  logic        err_drop;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  byte_word_packer #(
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .flush      (flush),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .byte_cnt   (byte_cnt),
    .err_drop   (err_drop)
  );

  // Scoreboard: compare each handed-over word with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && word_valid === 1'b1 && word_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_word: got %h, expected no word", word_data);
      end else begin
        logic [31:0] exp_w;
        exp_w = sb.pop_front();
        if (word_data !== exp_w) begin
          errors++;
          $display("FAIL sb_word: got %h, expected %h", word_data, exp_w);
        end
      end
    end
  end

  // Hard stop if anything hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic drive_byte(input logic [7:0] b);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (byte_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: byte %h never accepted, byte_ready=%b", b, byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_word_valid", 32'(word_valid), 32'd0);
    chk("reset_word_data", word_data, 32'd0);
    chk("reset_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("reset_err_drop", 32'(err_drop), 32'd0);
    chk("reset_byte_ready", 32'(byte_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    word_ready = 1'b1;
    sb.push_back(32'h44332211);
    drive_byte(8'h11);
    drive_byte(8'h22);
    drive_byte(8'h33);
    chk("single_cnt_before_last", 32'(byte_cnt), 32'd3);
    chk("single_valid_before_last", 32'(word_valid), 32'd0);
    chk("single_partial_lanes", word_data, 32'h00332211);
    drive_byte(8'h44);
    chk("single_valid_latency", 32'(word_valid), 32'd1);
    chk("single_word_data", word_data, 32'h44332211);
    chk("single_cnt_wrap", 32'(byte_cnt), 32'd0);
    step();
    chk("single_valid_cleared", 32'(word_valid), 32'd0);
    chk("single_data_zeroed", word_data, 32'd0);
  endtask

  task automatic test_back_to_back();
    word_ready = 1'b1;
    sb.push_back(32'h04030201);
    sb.push_back(32'h08070605);
    byte_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      byte_data = 8'(i);
      @(negedge clk);
      chk($sformatf("b2b_ready_%0d", i), 32'(byte_ready), 32'd1);
      step();
    end
    byte_valid = 1'b0;
    chk("b2b_cnt_end", 32'(byte_cnt), 32'd0);
    chk("b2b_valid_end", 32'(word_valid), 32'd1);
    step();
  endtask

  task automatic test_stall();
    word_ready = 1'b0;
    sb.push_back(32'h04030201);
    drive_byte(8'h01);
    drive_byte(8'h02);
    drive_byte(8'h03);
    drive_byte(8'h04);
    byte_valid = 1'b1;
    byte_data  = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_ready_%0d", i), 32'(byte_ready), 32'd0);
      chk($sformatf("stall_data_%0d", i), word_data, 32'h04030201);
      chk($sformatf("stall_valid_%0d", i), 32'(word_valid), 32'd1);
      step();
    end
    word_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(byte_ready), 32'd1);
    step();
    byte_valid = 1'b0;
    chk("stall_lane0_cnt", 32'(byte_cnt), 32'd1);
    chk("stall_lane0_data", word_data, 32'h00000005);
    chk("stall_lane0_valid", 32'(word_valid), 32'd0);
    sb.push_back(32'h08070605);
    drive_byte(8'h06);
    drive_byte(8'h07);
    drive_byte(8'h08);
    step();
  endtask

  task automatic test_flush();
    word_ready = 1'b1;
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    chk("flush_cnt_before", 32'(byte_cnt), 32'd2);
    chk("flush_partial_data", word_data, 32'h0000BBAA);
    flush      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hCC;
    @(negedge clk);
    chk("flush_ready_low", 32'(byte_ready), 32'd0);
    step();
    flush      = 1'b0;
    byte_valid = 1'b0;
    chk("flush_cnt_after", 32'(byte_cnt), 32'd0);
    chk("flush_data_after", word_data, 32'd0);
    sb.push_back(32'h04030201);
    drive_byte(8'h01);
    drive_byte(8'h02);
    drive_byte(8'h03);
    drive_byte(8'h04);
    step();
    // Flush while a complete word is pending must not disturb it.
    word_ready = 1'b0;
    sb.push_back(32'h0D0C0B0A);
    drive_byte(8'h0A);
    drive_byte(8'h0B);
    drive_byte(8'h0C);
    drive_byte(8'h0D);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_pending_valid", 32'(word_valid), 32'd1);
    chk("flush_pending_data", word_data, 32'h0D0C0B0A);
    word_ready = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    word_ready = 1'b1;
    drive_byte(8'h21);
    drive_byte(8'h22);
    drive_byte(8'h23);
    chk("areset_cnt_before", 32'(byte_cnt), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(word_valid), 32'd0);
    chk("areset_cnt", 32'(byte_cnt), 32'd0);
    chk("areset_data", word_data, 32'd0);
    chk("areset_err_drop", 32'(err_drop), 32'd0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    word_ready = 1'b1;
`ifdef PACKER_TIMEOUT_EN
    drive_byte(8'h5A);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) begin
        chk($sformatf("to_idle_err_%0d", i), 32'(err_drop), 32'd0);
        chk($sformatf("to_idle_cnt_%0d", i), 32'(byte_cnt), 32'd1);
      end
    end
    chk("to_err_pulse", 32'(err_drop), 32'd1);
    chk("to_cnt_dropped", 32'(byte_cnt), 32'd0);
    chk("to_data_dropped", word_data, 32'd0);
    step();
    chk("to_err_one_cycle", 32'(err_drop), 32'd0);
    // A byte accepted in the expiry cycle wins.
    drive_byte(8'h5A);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("to_win_idle_err_%0d", i), 32'(err_drop), 32'd0);
    end
    drive_byte(8'h5B);
    chk("to_win_err", 32'(err_drop), 32'd0);
    chk("to_win_cnt", 32'(byte_cnt), 32'd2);
    chk("to_win_data", word_data, 32'h00005B5A);
    step();
    chk("to_win_err_next", 32'(err_drop), 32'd0);
`else
    drive_byte(8'h5A);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("noto_err_%0d", i), 32'(err_drop), 32'd0);
    end
    chk("noto_cnt_kept", 32'(byte_cnt), 32'd1);
    chk("noto_data_kept", word_data, 32'h0000005A);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("timeout_cleanup_cnt", 32'(byte_cnt), 32'd0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_timeout();
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_byte_word_packer
